axi4_lite_slave_regfile: RTL and testbench

AXI4-Lite slave register file: the endpoint that receives the transactions the AXI4-Lite master issues on the framework bus. It accepts write address and write data independently, commits byte-strobed writes to a bank of `NUM_REGS` registers, returns write responses, and serves single-beat reads. Out-of-range accesses are flagged with SLVERR. This block is the downstream stage the master wrapper connects to in the bench.

---
 rtl/axi4_lite_slave_regfile.sv | 101 ++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite slave with a byte-strobed register bank.
// Write address/data are latched independently; a commit occurs once both are held.
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    s_AWVALID,
    output logic                    s_AWREADY,
    input  logic [ADDR_WIDTH-1:0]   s_AWADDR,
    input  logic [2:0]              s_AWPROT,
    input  logic                    s_WVALID,
    output logic                    s_WREADY,
    input  logic [DATA_WIDTH-1:0]   s_WDATA,
    input  logic [DATA_WIDTH/8-1:0] s_WSTRB,
    output logic                    s_BVALID,
    input  logic                    s_BREADY,
    output logic [1:0]              s_BRESP,
    input  logic                    s_ARVALID,
    output logic                    s_ARREADY,
    input  logic [ADDR_WIDTH-1:0]   s_ARADDR,
    input  logic [2:0]              s_ARPROT,
    output logic                    s_RVALID,
    input  logic                    s_RREADY,
    output logic [DATA_WIDTH-1:0]   s_RDATA,
    output logic [1:0]              s_RRESP
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_full, w_full;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  wr_in, rd_in;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  unused;

    assign s_AWREADY = !aw_full && !s_BVALID;
    assign s_WREADY  = !w_full && !s_BVALID;
    assign s_ARREADY = !s_RVALID;
    // Any set bit above the index field puts the access out of range
    assign wr_in  = (aw_addr >> (OFF + IDX_W)) == '0;
    assign rd_in  = (s_ARADDR >> (OFF + IDX_W)) == '0;
    assign wr_idx = aw_addr[OFF +: IDX_W];
    assign rd_idx = s_ARADDR[OFF +: IDX_W];
    assign unused = ^{s_AWPROT, s_ARPROT, aw_addr[OFF-1:0], s_ARADDR[OFF-1:0]};

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s_BVALID <= 1'b0;
            s_BRESP  <= 2'b00;
            s_RVALID <= 1'b0;
            s_RDATA  <= '0;
            s_RRESP  <= 2'b00;
        end else begin
            if (aw_full && w_full) begin
                for (int i = 0; i < STRB_W; i++)
                    if (wr_in && w_strb[i]) regs[wr_idx][i*8 +: 8] <= w_data[i*8 +: 8];
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                s_BVALID <= 1'b1;
                s_BRESP  <= wr_in ? 2'b00 : 2'b10;
            end else begin
                if (s_AWVALID && s_AWREADY) begin
                    aw_full <= 1'b1;
                    aw_addr <= s_AWADDR;
                end
                if (s_WVALID && s_WREADY) begin
                    w_full <= 1'b1;
                    w_data <= s_WDATA;
                    w_strb <= s_WSTRB;
                end
            end
            if (s_BVALID && s_BREADY) begin
                s_BVALID <= 1'b0;
                s_BRESP  <= 2'b00;
            end
            // Nonblocking read of regs yields the pre-commit value on a same-edge collision
            if (s_ARVALID && s_ARREADY) begin
                s_RVALID <= 1'b1;
                s_RDATA  <= rd_in ? regs[rd_idx] : '0;
                s_RRESP  <= rd_in ? 2'b00 : 2'b10;
            end else if (s_RVALID && s_RREADY) begin
                s_RVALID <= 1'b0;
                s_RDATA  <= '0;
                s_RRESP  <= 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile: scoreboard bench with a register-array reference model.
// Inputs change 2ns after a rising edge; outputs and handshakes are observed on falling edges.
module tb_axi4_lite_slave_regfile;
    logic        iCLK = 1'b0, iRST = 1'b0;
    logic        s_AWVALID = 0, s_AWREADY, s_WVALID = 0, s_WREADY, s_BVALID, s_BREADY = 1;
    logic        s_ARVALID = 0, s_ARREADY, s_RVALID, s_RREADY = 1;
    logic [31:0] s_AWADDR = 0, s_ARADDR = 0, s_WDATA = 0, s_RDATA;
    logic [3:0]  s_WSTRB = 0;
    logic [1:0]  s_BRESP, s_RRESP;

    int          checks = 0, failures = 0;
    logic [31:0] mem [16];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];
    bit          bp_en = 0;

    axi4_lite_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(3'b000),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
        .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(3'b000),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP)
    );

    initial forever #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return a < 32'd64;
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    task automatic step();
        @(posedge iCLK);
        #2;
    endtask

    task automatic drain_b();
        for (int n = 0; b_q.size() != 0; n++) begin
            if (n == 200) begin timeout("b_drain"); b_q.delete(); break; end
            @(negedge iCLK);
        end
        step();
    endtask

    task automatic drain_r();
        for (int n = 0; r_q.size() != 0; n++) begin
            if (n == 200) begin timeout("r_drain"); r_q.delete(); break; end
            @(negedge iCLK);
        end
        step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        if (in_rng(a)) begin
            for (int i = 0; i < 4; i++) if (s[i]) mem[idx(a)][i*8 +: 8] = d[i*8 +: 8];
            b_q.push_back(2'b00);
        end else b_q.push_back(2'b10);
        fork
            begin
                repeat (aw_dly) step();
                s_AWVALID = 1; s_AWADDR = a;
                for (int n = 0; ; n++) begin
                    @(negedge iCLK);
                    if (s_AWREADY) break;
                    if (n == 50) begin timeout("aw_handshake"); break; end
                end
                step();
                s_AWVALID = 0;
            end
            begin
                repeat (w_dly) step();
                s_WVALID = 1; s_WDATA = d; s_WSTRB = s;
                for (int n = 0; ; n++) begin
                    @(negedge iCLK);
                    if (s_WREADY) break;
                    if (n == 50) begin timeout("w_handshake"); break; end
                end
                step();
                s_WVALID = 0;
            end
        join
        drain_b();
    endtask

    task automatic do_read(input logic [31:0] a, input int dly);
        r_q.push_back({in_rng(a) ? mem[idx(a)] : 32'h0, in_rng(a) ? 2'b00 : 2'b10});
        repeat (dly) step();
        s_ARVALID = 1; s_ARADDR = a;
        for (int n = 0; ; n++) begin
            @(negedge iCLK);
            if (s_ARREADY) break;
            if (n == 50) begin timeout("ar_handshake"); break; end
        end
        step();
        s_ARVALID = 0;
        drain_r();
    endtask

    // Monitor: pops the expected response whenever the DUT completes a B or R handshake
    initial forever begin
        @(negedge iCLK);
        if (iRST && s_BVALID && s_BREADY) begin
            if (b_q.size() == 0) timeout("unexpected_b");
            else chk("bresp", s_BRESP, b_q.pop_front());
        end
        if (iRST && s_RVALID && s_RREADY) begin
            if (r_q.size() == 0) timeout("unexpected_r");
            else begin
                logic [33:0] e;
                e = r_q.pop_front();
                chk("rdata", s_RDATA, e[33:2]);
                chk("rresp", s_RRESP, e[1:0]);
            end
        end
    end

    initial forever begin
        step();
        if (bp_en) begin
            s_BREADY = ($urandom % 3) != 0;
            s_RREADY = ($urandom % 3) != 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, old;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        @(negedge iCLK);
        chk("rst_bvalid", s_BVALID, 0);
        chk("rst_rvalid", s_RVALID, 0);
        chk("rst_awready", s_AWREADY, 1);
        chk("rst_wready", s_WREADY, 1);
        chk("rst_arready", s_ARREADY, 1);
        chk("rst_rdata", s_RDATA, 0);
        chk("rst_bresp", {s_BRESP, s_RRESP}, 0);
        step();
        iRST = 1;
        step();

        // Simultaneous AW/W with B backpressure: BVALID first in cycle N+2, then held
        s_BREADY = 0;
        s_AWVALID = 1; s_AWADDR = 32'h4; s_WVALID = 1; s_WDATA = 32'hDEADBEEF; s_WSTRB = 4'hF;
        mem[1] = 32'hDEADBEEF; b_q.push_back(2'b00);
        @(negedge iCLK);
        chk("n_awready", s_AWREADY, 1);
        chk("n_wready", s_WREADY, 1);
        step();
        s_AWVALID = 0; s_WVALID = 0;
        @(negedge iCLK);
        chk("n1_bvalid", s_BVALID, 0);
        chk("n1_awready", s_AWREADY, 0);
        @(negedge iCLK);
        chk("n2_bvalid", s_BVALID, 1);
        repeat (5) begin
            @(negedge iCLK);
            chk("bp_bvalid", s_BVALID, 1);
            chk("bp_bresp", s_BRESP, 0);
            chk("bp_readies", {s_AWREADY, s_WREADY}, 0);
        end
        step();
        s_BREADY = 1;
        drain_b();
        do_read(32'h4, 0);
        do_write(32'h4, 32'h12345678, 4'h3, 0, 0);
        do_read(32'h4, 1);

        // W presented in cycle 0, AW in cycle 3
        s_WVALID = 1; s_WDATA = 32'hCAFE0123; s_WSTRB = 4'hF;
        mem[2] = 32'hCAFE0123; b_q.push_back(2'b00);
        @(negedge iCLK);
        chk("wfirst_c0_wready", s_WREADY, 1);
        step();
        s_WVALID = 0;
        @(negedge iCLK);
        chk("wfirst_c1_wready", s_WREADY, 0);
        step();
        @(negedge iCLK);
        chk("wfirst_c2_wready", s_WREADY, 0);
        step();
        s_AWVALID = 1; s_AWADDR = 32'h8;
        @(negedge iCLK);
        chk("wfirst_c3_wready", s_WREADY, 0);
        chk("wfirst_c3_awready", s_AWREADY, 1);
        step();
        s_AWVALID = 0;
        @(negedge iCLK);
        chk("wfirst_c4_bvalid", s_BVALID, 0);
        @(negedge iCLK);
        chk("wfirst_c5_bvalid", s_BVALID, 1);
        drain_b();
        do_read(32'h8, 0);

        // Out-of-range write leaves every register intact; out-of-range read returns SLVERR
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
        for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);
        do_read(32'h40, 0);
        do_write(32'h8000_0004, 32'h11111111, 4'hF, 1, 0);
        do_write(32'h14, 32'h55555555, 4'h0, 0, 0);
        do_read(32'h14, 0);

        // Read backpressure
        s_RREADY = 0;
        s_ARVALID = 1; s_ARADDR = 32'h4;
        r_q.push_back({mem[1], 2'b00});
        @(negedge iCLK);
        chk("rbp_arready", s_ARREADY, 1);
        step();
        s_ARVALID = 0;
        repeat (5) begin
            @(negedge iCLK);
            chk("rbp_rvalid", s_RVALID, 1);
            chk("rbp_rdata", s_RDATA, mem[1]);
            chk("rbp_arready", s_ARREADY, 0);
        end
        step();
        s_RREADY = 1;
        drain_r();

        // Read sampled on the commit edge of a write to the same register
        do_write(32'hC, 32'hAAAA0000, 4'hF, 0, 0);
        s_AWVALID = 1; s_AWADDR = 32'hC; s_WVALID = 1; s_WDATA = 32'h0BADF00D; s_WSTRB = 4'hF;
        step();
        s_AWVALID = 0; s_WVALID = 0;
        s_ARVALID = 1; s_ARADDR = 32'hC;
        r_q.push_back({mem[3], 2'b00});
        b_q.push_back(2'b00);
        mem[3] = 32'h0BADF00D;
        step();
        s_ARVALID = 0;
        fork drain_b(); drain_r(); join
        do_read(32'hC, 0);

        // Concurrent traffic on disjoint registers
        fork
            for (int i = 0; i < 8; i++) do_write(32'(i * 4), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            for (int i = 8; i < 16; i++) do_read(32'(i * 4), $urandom_range(0, 2));
        join
        for (int i = 0; i < 8; i++) do_read(32'(i * 4), 0);

        // Randomized sequential traffic with random B/R backpressure
        bp_en = 1;
        repeat (60) begin
            a = ($urandom % 8 == 0) ? (32'h8000_0000 | 32'($urandom_range(0, 15) * 4)) : 32'($urandom_range(0, 79));
            if ($urandom % 2) do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            else do_read(a, $urandom_range(0, 2));
        end
        bp_en = 0;
        step();
        s_BREADY = 1; s_RREADY = 1;

        // Reset after AW handshake, before W
        s_AWVALID = 1; s_AWADDR = 32'hC;
        @(negedge iCLK);
        chk("mid_awready", s_AWREADY, 1);
        step();
        s_AWVALID = 0;
        @(negedge iCLK);
        chk("mid_aw_held", s_AWREADY, 0);
        #1 iRST = 0;
        #1;
        chk("mid_rst_readies", {s_AWREADY, s_WREADY, s_ARREADY}, 3'b111);
        chk("mid_rst_valids", {s_BVALID, s_RVALID}, 0);
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        step();
        iRST = 1;
        step();
        for (int i = 0; i < 16; i++) do_read(32'(i * 4), 0);
        old = $urandom;
        do_write(32'hC, old, 4'hF, 0, 0);
        do_read(32'hC, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
